// File: rtl/axis_cpu_pipe_ctl_pkg.sv
// Shared definitions for the axis_cpu pipeline sequencer.
// Contents: FSM state encoding and the default PC-advance counter width.
// No ports; imported by the sequencer top.
package axis_cpu_pipe_ctl_pkg;

    // Default width of the per-instruction PC-advance counters.
    localparam int ICOUNT_WIDTH_DEFAULT = 6;

    // Host-visible run control states.
    typedef enum logic [1:0] {
        PIPE_IDLE  = 2'd0,
        PIPE_RUN   = 2'd1,
        PIPE_DRAIN = 2'd2
    } pipe_state_t;

endpackage

// File: rtl/axis_cpu_sat_cnt.sv
// Saturating loadable up-counter.
// Ports: clk/rst (async active-high), load + load_val (priority), inc, count.
// Latency: count updates one cycle after load/inc; it holds at all-ones.
module axis_cpu_sat_cnt #(
    parameter int WIDTH = 6
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    input  logic             inc,
    output logic [WIDTH-1:0] count
);

    localparam logic [WIDTH-1:0] CNT_MAX = '1;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count <= '0;
        end else if (load) begin
            count <= load_val;
        end else if (inc && (count != CNT_MAX)) begin
            count <= count + 1'b1;
        end
    end

endmodule

// File: rtl/axis_cpu_pipe_ctl.sv
// Pipeline sequencer for the three-stage axis_cpu: stage valids, PC/latch enables,
// stage1/stage2 hazard detection, mispredict flush, per-instruction PC-advance count.
// Ports: host start/halt_req, stage hazard inputs, stage2_rdy/branch_mispredict in;
// PC_en, stage enables/valids, hazard, icount, busy out. Enables are combinational.
module axis_cpu_pipe_ctl
    import axis_cpu_pipe_ctl_pkg::*;
#(
    parameter int ICOUNT_WIDTH = ICOUNT_WIDTH_DEFAULT
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    start,
    input  logic                    halt_req,
    input  logic                    stage1_reads_A,
    input  logic                    stage1_reads_X,
    input  logic                    stage1_reads_imm,
    input  logic                    stage2_writes_A,
    input  logic                    stage2_writes_X,
    input  logic                    stage2_writes_imm,
    input  logic                    stage2_rdy,
    input  logic                    branch_mispredict,
    output logic                    PC_en,
    output logic                    stage1_vld,
    output logic                    stage1_en,
    output logic                    stage2_vld,
    output logic                    stage2_en,
    output logic                    hazard,
    output logic [ICOUNT_WIDTH-1:0] icount,
    output logic                    busy
);

    localparam logic [ICOUNT_WIDTH-1:0] CNT_MAX = '1;
    localparam logic [ICOUNT_WIDTH-1:0] CNT_ONE = {{(ICOUNT_WIDTH-1){1'b0}}, 1'b1};

    pipe_state_t state_q;
    pipe_state_t state_d;

    logic                    mispredict;
    logic                    fetch_ok;
    logic                    s2_fire;
    logic                    s2_free;
    logic                    s1_adv;
    logic                    s1_free;
    logic                    pc_step;
    logic [ICOUNT_WIDTH-1:0] s1_cnt;
    logic [ICOUNT_WIDTH-1:0] s2_cnt;
    logic [ICOUNT_WIDTH-1:0] s2_load_val;

    // The mispredict input is combinational straight through to PC_en; mask it
    // so every output is quiet while reset is held.
    assign mispredict = branch_mispredict && !rst;

    // ------------------------------------------------------------------
    // Run/drain/idle FSM
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= PIPE_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        busy    = 1'b1;
        case (state_q)
            PIPE_IDLE: begin
                busy = 1'b0;
                // start wins over a simultaneous halt_req
                if (start) begin
                    state_d = PIPE_RUN;
                end
            end
            PIPE_RUN: begin
                if (halt_req) begin
                    state_d = PIPE_DRAIN;
                end
            end
            PIPE_DRAIN: begin
                if (!stage1_vld && !stage2_vld) begin
                    state_d = PIPE_IDLE;
                end
            end
            default: begin
                state_d = PIPE_IDLE;
            end
        endcase
    end

    assign fetch_ok = (state_q == PIPE_RUN);

    // ------------------------------------------------------------------
    // Handshake / hazard logic
    // ------------------------------------------------------------------
    assign s2_fire = stage2_vld && stage2_rdy;
    assign s2_free = !stage2_vld || stage2_rdy;

    // Raised even when stage2 retires this cycle: its write lands at the
    // edge, so the operand stage1 reads now is still the old value.
    assign hazard = stage1_vld && ((stage1_reads_A   && stage2_writes_A) ||
                                   (stage1_reads_X   && stage2_writes_X) ||
                                   (stage1_reads_imm && stage2_writes_imm));

    assign s1_adv  = stage1_vld && s2_free && !hazard && !mispredict;
    assign s1_free = !stage1_vld || s1_adv;

    // A mispredict reloads the PC regardless of run state.
    assign PC_en     = mispredict || (fetch_ok && s1_free);
    assign stage1_en = fetch_ok && s1_free && !mispredict;
    assign stage2_en = s1_adv;

    // ------------------------------------------------------------------
    // Stage valid bits
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stage1_vld <= 1'b0;
            stage2_vld <= 1'b0;
        end else if (mispredict) begin
            stage1_vld <= 1'b0;
            stage2_vld <= 1'b0;
        end else begin
            if (s1_adv) begin
                stage2_vld <= 1'b1;
            end else if (s2_fire) begin
                stage2_vld <= 1'b0;
            end
            if (s1_free) begin
                stage1_vld <= fetch_ok;
            end
        end
    end

    // ------------------------------------------------------------------
    // PC-advance accounting
    // ------------------------------------------------------------------
    // A PC step that is not a mispredict reload counts against every
    // instruction already resident; a freshly loaded one is handled by load.
    assign pc_step = PC_en && !mispredict;

    // The stage1 instruction carries the PC step of the cycle it advances
    // into stage2 (none while draining, since PC_en is low then).
    assign s2_load_val = (pc_step && (s1_cnt != CNT_MAX)) ? (s1_cnt + 1'b1) : s1_cnt;

    axis_cpu_sat_cnt #(
        .WIDTH (ICOUNT_WIDTH)
    ) u_s1_cnt (
        .clk      (clk),
        .rst      (rst),
        .load     (stage1_en),
        .load_val (CNT_ONE),
        .inc      (pc_step && stage1_vld),
        .count    (s1_cnt)
    );

    axis_cpu_sat_cnt #(
        .WIDTH (ICOUNT_WIDTH)
    ) u_s2_cnt (
        .clk      (clk),
        .rst      (rst),
        .load     (s1_adv),
        .load_val (s2_load_val),
        .inc      (pc_step && stage2_vld),
        .count    (s2_cnt)
    );

    assign icount = s2_cnt;

endmodule

// File: tb/tb_axis_cpu_pipe_ctl.sv
// Directed bench for axis_cpu_pipe_ctl: reset, straight-line run, hazard,
// stage2 stall, mispredict flush, drain, idle-state halt and async reset mid-run.
// Inputs change 1 time unit after the rising edge; outputs are checked 2 units later.
module tb_axis_cpu_pipe_ctl;

    logic       clk;
    logic       rst;
    logic       start;
    logic       halt_req;
    logic       stage1_reads_A;
    logic       stage1_reads_X;
    logic       stage1_reads_imm;
    logic       stage2_writes_A;
    logic       stage2_writes_X;
    logic       stage2_writes_imm;
    logic       stage2_rdy;
    logic       branch_mispredict;
    logic       PC_en;
    logic       stage1_vld;
    logic       stage1_en;
    logic       stage2_vld;
    logic       stage2_en;
    logic       hazard;
    logic [5:0] icount;
    logic       busy;

    int n_tests;
    int n_fail;

    axis_cpu_pipe_ctl #(
        .ICOUNT_WIDTH (6)
    ) dut (
        .clk               (clk),
        .rst               (rst),
        .start             (start),
        .halt_req          (halt_req),
        .stage1_reads_A    (stage1_reads_A),
        .stage1_reads_X    (stage1_reads_X),
        .stage1_reads_imm  (stage1_reads_imm),
        .stage2_writes_A   (stage2_writes_A),
        .stage2_writes_X   (stage2_writes_X),
        .stage2_writes_imm (stage2_writes_imm),
        .stage2_rdy        (stage2_rdy),
        .branch_mispredict (branch_mispredict),
        .PC_en             (PC_en),
        .stage1_vld        (stage1_vld),
        .stage1_en         (stage1_en),
        .stage2_vld        (stage2_vld),
        .stage2_en         (stage2_en),
        .hazard            (hazard),
        .icount            (icount),
        .busy              (busy)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        n_tests++;
        assert (obs === exp)
        else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Advance to 1 unit after the next rising edge.
    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    initial begin
        n_tests           = 0;
        n_fail            = 0;
        rst               = 1'b1;
        start             = 1'b0;
        halt_req          = 1'b0;
        stage1_reads_A    = 1'b1;
        stage1_reads_X    = 1'b0;
        stage1_reads_imm  = 1'b0;
        stage2_writes_A   = 1'b1;
        stage2_writes_X   = 1'b0;
        stage2_writes_imm = 1'b0;
        stage2_rdy        = 1'b0;
        branch_mispredict = 1'b1;

        // ---------------- reset: everything quiet, even with mispredict high
        #12;
        chk("rst_pc_en",   PC_en, 0);
        chk("rst_busy",    busy, 0);
        chk("rst_s1_vld",  stage1_vld, 0);
        chk("rst_s2_vld",  stage2_vld, 0);
        chk("rst_s1_en",   stage1_en, 0);
        chk("rst_s2_en",   stage2_en, 0);
        chk("rst_hazard",  hazard, 0);
        chk("rst_icount",  icount, 0);
        rst               = 1'b0;
        branch_mispredict = 1'b0;
        stage1_reads_A    = 1'b0;
        stage2_writes_A   = 1'b0;

        // ---------------- straight-line run
        tick;
        start      = 1'b1;
        stage2_rdy = 1'b1;
        #2;
        chk("idle_pc_en", PC_en, 0);
        chk("idle_busy",  busy, 0);
        tick;                       // RUN cycle 1
        start = 1'b0;
        #2;
        chk("run1_busy",   busy, 1);
        chk("run1_pc_en",  PC_en, 1);
        chk("run1_s1_en",  stage1_en, 1);
        chk("run1_s1_vld", stage1_vld, 0);
        tick;                       // RUN cycle 2
        #2;
        chk("run2_s1_vld", stage1_vld, 1);
        chk("run2_s2_en",  stage2_en, 1);
        chk("run2_pc_en",  PC_en, 1);
        chk("run2_s2_vld", stage2_vld, 0);
        tick;                       // RUN cycle 3
        #2;
        chk("run3_s2_vld",  stage2_vld, 1);
        chk("run3_icount",  icount, 2);
        chk("run3_pc_en",   PC_en, 1);
        tick;                       // RUN cycle 4
        #2;
        chk("run4_icount",  icount, 2);
        chk("run4_pc_en",   PC_en, 1);

        // ---------------- register hazard for two cycles
        stage1_reads_A  = 1'b1;
        stage2_writes_A = 1'b1;
        #2;
        chk("haz1_hazard", hazard, 1);
        chk("haz1_s2_en",  stage2_en, 0);
        chk("haz1_pc_en",  PC_en, 0);
        chk("haz1_s1_en",  stage1_en, 0);
        tick;
        #2;
        chk("haz2_hazard", hazard, 1);
        chk("haz2_s2_en",  stage2_en, 0);
        chk("haz2_pc_en",  PC_en, 0);
        chk("haz2_s2_vld", stage2_vld, 0);
        tick;
        stage1_reads_A  = 1'b0;
        stage2_writes_A = 1'b0;
        #2;
        chk("haz3_hazard", hazard, 0);
        chk("haz3_s2_en",  stage2_en, 1);
        chk("haz3_pc_en",  PC_en, 1);
        tick;
        #2;
        chk("haz4_s2_vld", stage2_vld, 1);
        chk("haz4_icount", icount, 2);

        // ---------------- stage2 stall, both stages full
        stage2_rdy = 1'b0;
        #2;
        chk("stall1_pc_en", PC_en, 0);
        chk("stall1_s2_en", stage2_en, 0);
        chk("stall1_s1_en", stage1_en, 0);
        for (int i = 2; i <= 4; i++) begin
            tick;
            #2;
            chk("stall_pc_en",  PC_en, 0);
            chk("stall_icount", icount, 2);
            chk("stall_s2_vld", stage2_vld, 1);
            chk("stall_s1_vld", stage1_vld, 1);
        end
        tick;
        stage2_rdy = 1'b1;
        #2;
        chk("unstall_pc_en", PC_en, 1);
        chk("unstall_s2_en", stage2_en, 1);
        tick;
        #2;
        chk("unstall_icount", icount, 2);
        chk("unstall_s2_vld", stage2_vld, 1);

        // ---------------- mispredict flush with both stages valid
        branch_mispredict = 1'b1;
        #2;
        chk("mp_pc_en", PC_en, 1);
        chk("mp_s1_en", stage1_en, 0);
        chk("mp_s2_en", stage2_en, 0);
        tick;
        branch_mispredict = 1'b0;
        #2;
        chk("mp1_s1_vld", stage1_vld, 0);
        chk("mp1_s2_vld", stage2_vld, 0);
        chk("mp1_s1_en",  stage1_en, 1);
        chk("mp1_pc_en",  PC_en, 1);
        tick;
        #2;
        chk("mp2_s1_vld", stage1_vld, 1);
        chk("mp2_s2_vld", stage2_vld, 0);
        tick;
        #2;
        chk("mp3_s2_vld", stage2_vld, 1);
        chk("mp3_icount", icount, 2);

        // ---------------- drain
        halt_req = 1'b1;
        #2;
        chk("halt_busy", busy, 1);
        tick;                       // first DRAIN cycle
        halt_req = 1'b0;
        #2;
        chk("dr1_s1_en", stage1_en, 0);
        chk("dr1_pc_en", PC_en, 0);
        chk("dr1_s2_en", stage2_en, 1);
        chk("dr1_busy",  busy, 1);
        tick;
        #2;
        chk("dr2_s1_vld", stage1_vld, 0);
        chk("dr2_s2_vld", stage2_vld, 1);
        chk("dr2_icount", icount, 1);
        chk("dr2_s1_en",  stage1_en, 0);
        chk("dr2_busy",   busy, 1);
        tick;
        #2;
        chk("dr3_s2_vld", stage2_vld, 0);
        chk("dr3_busy",   busy, 1);
        tick;
        #2;
        chk("dr4_busy",  busy, 0);
        chk("dr4_pc_en", PC_en, 0);

        // ---------------- halt_req alone in IDLE is ignored
        halt_req = 1'b1;
        tick;
        halt_req = 1'b0;
        #2;
        chk("idle_halt_busy", busy, 0);

        // ---------------- start+halt together in IDLE: run
        start    = 1'b1;
        halt_req = 1'b1;
        tick;
        start    = 1'b0;
        halt_req = 1'b0;
        #2;
        chk("sh_busy",  busy, 1);
        chk("sh_pc_en", PC_en, 1);
        tick;
        tick;
        #2;
        chk("sh_s2_vld", stage2_vld, 1);
        chk("sh_icount", icount, 2);

        // ---------------- async reset in the middle of a stall
        stage2_rdy = 1'b0;
        #2;
        chk("pre_rst_pc_en", PC_en, 0);
        rst = 1'b1;
        #1;
        chk("arst_pc_en",  PC_en, 0);
        chk("arst_s1_vld", stage1_vld, 0);
        chk("arst_s2_vld", stage2_vld, 0);
        chk("arst_busy",   busy, 0);
        chk("arst_icount", icount, 0);
        chk("arst_s1_en",  stage1_en, 0);
        #2;
        rst = 1'b0;
        tick;
        start      = 1'b1;
        stage2_rdy = 1'b1;
        #2;
        chk("rs_idle_busy", busy, 0);
        tick;
        start = 1'b0;
        #2;
        chk("rs_busy",  busy, 1);
        chk("rs_pc_en", PC_en, 1);
        tick;
        tick;
        #2;
        chk("rs_s2_vld", stage2_vld, 1);
        chk("rs_icount", icount, 2);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
